// File: rtl/game_state_ctrl.sv
// Snake game-flow controller: PS/2 key decode, init pulse, lives, screen select.
// Optional lives counter enabled by defining GAME_STATE_LIVES_EN.
module game_state_ctrl #(
    parameter logic [7:0] KEY_START   = 8'h1B,
    parameter logic [7:0] KEY_ESC     = 8'h76,
    parameter logic [7:0] KEY_PAUSE   = 8'h4D,
    parameter logic [7:0] KEY_RESUME  = 8'h2D,
    parameter logic [7:0] BREAK_CODE  = 8'hF0,
    parameter int         INIT_CYCLES = 4,
    parameter int         NUM_LIVES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic       died,
    output logic       init_snake,
    output logic       screen_black,
    output logic       screen_pause,
    output logic       game_over,
    output logic [3:0] lives,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_BLACK = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       brk_q;
    logic       died_q;
    logic       key_ev, k_start, k_esc, k_pause, k_resume;
    logic       die_ev, last_life;
    logic       load_lives, dec_lives;

    // Byte after a break prefix is the released key and must not act.
    assign key_ev   = key_valid && !brk_q && (key_code != BREAK_CODE);
    assign k_start  = key_ev && (key_code == KEY_START);
    assign k_esc    = key_ev && (key_code == KEY_ESC);
    assign k_pause  = key_ev && (key_code == KEY_PAUSE);
    assign k_resume = key_ev && (key_code == KEY_RESUME);
    assign die_ev   = died && !died_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BLACK;
            cnt_q   <= '0;
            brk_q   <= 1'b0;
            died_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            died_q  <= died;
            if (key_valid) begin
                if (brk_q)
                    brk_q <= 1'b0;
                else if (key_code == BREAK_CODE)
                    brk_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        load_lives = 1'b0;
        dec_lives  = 1'b0;
        unique case (state_q)
            S_BLACK: begin
                if (k_start) begin
                    state_d    = S_INIT;
                    load_lives = 1'b1;
                end
            end
            S_INIT: begin
                if (k_start) begin
                    load_lives = 1'b1;
                end else if (k_esc) begin
                    state_d = S_BLACK;
                end else if (cnt_q == INIT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                if (k_start) begin
                    state_d    = S_INIT;
                    load_lives = 1'b1;
                end else if (k_esc) begin
                    state_d = S_BLACK;
                end else if (k_pause) begin
                    state_d = S_PAUSE;
                end else if (die_ev) begin
                    dec_lives = 1'b1;
                    state_d   = last_life ? S_OVER : S_INIT;
                end
            end
            S_PAUSE: begin
                if (k_start) begin
                    state_d    = S_INIT;
                    load_lives = 1'b1;
                end else if (k_resume) begin
                    state_d = S_RUN;
                end else if (k_esc) begin
                    state_d = S_BLACK;
                end
            end
            S_OVER: begin
                if (k_start) begin
                    state_d    = S_INIT;
                    load_lives = 1'b1;
                end else if (k_esc) begin
                    state_d = S_BLACK;
                end
            end
            default: state_d = S_BLACK;
        endcase
    end

`ifdef GAME_STATE_LIVES_EN
    logic [3:0] lives_q;

    assign last_life = (lives_q <= 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lives_q <= 4'(NUM_LIVES);
        else if (load_lives)
            lives_q <= 4'(NUM_LIVES);
        else if (dec_lives && lives_q != 4'd0)
            lives_q <= lives_q - 4'd1;
    end

    assign lives = (state_q == S_OVER) ? 4'd0 : lives_q;
`else
    logic unused_lives;

    // Without a counter every death ends the game.
    assign last_life    = 1'b1;
    assign lives        = 4'd1;
    assign unused_lives = load_lives ^ dec_lives;
`endif

    assign state        = state_q;
    assign init_snake   = (state_q == S_INIT);
    assign screen_black = (state_q == S_BLACK);
    assign screen_pause = (state_q == S_PAUSE) || (state_q == S_OVER);
    assign game_over    = (state_q == S_OVER);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl; lives expectations follow
// GAME_STATE_LIVES_EN (tied to 1 when the macro is undefined).
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_code;
    logic       key_valid;
    logic       died;
    logic       init_snake;
    logic       screen_black;
    logic       screen_pause;
    logic       game_over;
    logic [3:0] lives;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    game_state_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .died         (died),
        .init_snake   (init_snake),
        .screen_black (screen_black),
        .screen_pause (screen_pause),
        .game_over    (game_over),
        .lives        (lives),
        .state        (state)
    );

    always #5 clk = ~clk;

`ifdef GAME_STATE_LIVES_EN
    function automatic logic [7:0] lv(input int n);
        return 8'(n);
    endfunction
`else
    function automatic logic [7:0] lv(input int n);
        return (n >= 0) ? 8'd1 : 8'd1;
    endfunction
`endif

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic pulse_died();
        died = 1'b1;
        tick();
        died = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        key_code  = 8'h00;
        key_valid = 1'b0;
        died      = 1'b0;
        #1;
        check("rst_state", 8'(state), 8'd0);
        check("rst_black", 8'(screen_black), 8'd1);
        check("rst_init", 8'(init_snake), 8'd0);
        check("rst_pause", 8'(screen_pause), 8'd0);
        check("rst_over", 8'(game_over), 8'd0);
        check("rst_lives", 8'(lives), lv(3));
        @(negedge clk);
        rst = 1'b0;
        tick();

        send(8'h1B);
        for (int i = 0; i < 4; i++) begin
            check("init_state", 8'(state), 8'd1);
            check("init_pulse", 8'(init_snake), 8'd1);
            tick();
        end
        check("run_state", 8'(state), 8'd2);
        check("run_init0", 8'(init_snake), 8'd0);
        check("run_lives", 8'(lives), lv(3));

        send(8'hF0);
        send(8'h1B);
        check("brk_state", 8'(state), 8'd2);
        tick();
        check("brk_hold", 8'(state), 8'd2);

        send(8'h4D);
        check("pause_scr", 8'(screen_pause), 8'd1);
        check("pause_st", 8'(state), 8'd3);
        send(8'h76);
        check("esc_black", 8'(screen_black), 8'd1);
        check("esc_state", 8'(state), 8'd0);

        send(8'h1B);
        ticks(4);
        check("run2_state", 8'(state), 8'd2);
`ifdef GAME_STATE_LIVES_EN
        pulse_died();
        check("d1_state", 8'(state), 8'd1);
        check("d1_lives", 8'(lives), 8'd2);
        ticks(4);
        check("d1_run", 8'(state), 8'd2);
        pulse_died();
        check("d2_state", 8'(state), 8'd1);
        check("d2_lives", 8'(lives), 8'd1);
        ticks(4);
        check("d2_run", 8'(state), 8'd2);
        pulse_died();
`else
        pulse_died();
`endif
        check("over_state", 8'(state), 8'd4);
        check("over_flag", 8'(game_over), 8'd1);
        check("over_pause", 8'(screen_pause), 8'd1);
        check("over_lives", 8'(lives), lv(0));

        send(8'h1B);
        check("restart_st", 8'(state), 8'd1);
        check("restart_lv", 8'(lives), lv(3));
        ticks(4);
        died = 1'b1;
        ticks(10);
        died = 1'b0;
`ifdef GAME_STATE_LIVES_EN
        check("hold_state", 8'(state), 8'd2);
        check("hold_lives", 8'(lives), 8'd2);
`else
        check("hold_state", 8'(state), 8'd4);
`endif

        send(8'h1B);
        ticks(4);
        check("run3_state", 8'(state), 8'd2);
        died = 1'b1;
        send(8'h4D);
        died = 1'b0;
        check("tie_state", 8'(state), 8'd3);
        check("tie_lives", 8'(lives), lv(3));
        send(8'h2D);
        check("resume_st", 8'(state), 8'd2);

        send(8'h1B);
        tick();
        check("mid_init", 8'(state), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_black", 8'(screen_black), 8'd1);
        check("arst_init", 8'(init_snake), 8'd0);
        check("arst_lives", 8'(lives), lv(3));
        check("arst_state", 8'(state), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        send(8'hF0);
        #2;
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        send(8'h1B);
        check("brk_rst", 8'(state), 8'd1);
        send(8'h76);
        check("init_esc", 8'(state), 8'd0);
        send(8'h4D);
        check("black_ign", 8'(state), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
